// File: rtl/accel_dma_port.sv
// accel_dma_port: block-copy DMA engine owning the shared data memory port
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cpu_mem_read/cpu_mem_write   CPU MEM-stage request, cpu_addr/cpu_wdata
//   cpu_rdata, cpu_stall         CPU load data, hold-request indication
//   start, src_addr, dst_addr,   single-cycle copy command with word addresses
//   len                          and word count (values above 1024 clamp to 1024)
//   busy, done, err              copy running, completion pulse, reject pulse
//   mem_read/mem_write, addr,    single request port to data memory
//   write_data, read_data        (read_data is combinational, same cycle)
//
// Build option: DMA_WINDOW_CHECK_EN rejects copies whose source or destination
// range crosses a 64K-word window (addr[18:16]); without it err is tied low
// and addresses wrap silently.
module accel_dma_port #(
    parameter int DW = 19,
    parameter int LW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_mem_read,
    input  logic          cpu_mem_write,
    input  logic [DW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          start,
    input  logic [DW-1:0] src_addr,
    input  logic [DW-1:0] dst_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          mem_read,
    output logic          mem_write,
    output logic [DW-1:0] addr,
    output logic [DW-1:0] write_data,
    input  logic [DW-1:0] read_data
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam logic [LW-1:0] MAX_LEN = LW'(1024);
    state_t state, state_nx;
    logic [LW-1:0] idx, len_r, len_c;
    logic [DW-1:0] src_r, dst_r, data_r;
    logic reject, last, accept;
    assign len_c  = (len > MAX_LEN) ? MAX_LEN : len;
    assign last   = idx == len_r - 1'b1;
    assign accept = state == IDLE && start && !reject;
`ifdef DMA_WINDOW_CHECK_EN
    logic [DW-1:0] src_end, dst_end;
    logic err_q;
    assign src_end = src_addr + DW'(len_c) - DW'(1);
    assign dst_end = dst_addr + DW'(len_c) - DW'(1);
    assign reject  = len_c != '0 && (src_addr[DW-1:DW-3] != src_end[DW-1:DW-3] ||
                                     dst_addr[DW-1:DW-3] != dst_end[DW-1:DW-3]);
    always_ff @(posedge clk or posedge rst)
        if (rst) err_q <= 1'b0;
        else     err_q <= state == IDLE && start && reject;
    assign err = err_q;
`else
    assign reject = 1'b0;
    assign err    = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state == IDLE ? (accept ? (len_c == '0 ? DONE : RD) : IDLE) :
                   state == RD   ? WR :
                   state == WR   ? (last ? DONE : RD) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            data_r <= '0;
        end else if (accept) begin
            idx   <= '0;
            src_r <= src_addr;
            dst_r <= dst_addr;
            len_r <= len_c;
        end else if (state == RD) begin
            data_r <= read_data;
        end else if (state == WR && !last) begin
            idx <= idx + 1'b1;
        end
    end
    // Pass-through drops a read that collides with a write so the memory never
    // sees both strobes at once.
    always_comb begin
        busy       = state == RD || state == WR;
        done       = state == DONE;
        mem_read   = state == RD || (!busy && cpu_mem_read && !cpu_mem_write);
        mem_write  = state == WR || (!busy && cpu_mem_write);
        addr       = state == RD ? src_r + DW'(idx) :
                     state == WR ? dst_r + DW'(idx) : cpu_addr;
        write_data = state == WR ? data_r : busy ? '0 : cpu_wdata;
        cpu_rdata  = busy ? '0 : read_data;
        cpu_stall  = busy && (cpu_mem_read || cpu_mem_write);
    end
endmodule
